// File: rtl/crash_course_cpu_pkg.sv
// Shared types and constants for the crash-course CPU fetch path.
package crash_course_cpu_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam logic [INSTR_WIDTH-1:0] NOP = 16'h0000;

  localparam int COND_ZERO  = 0;
  localparam int COND_NEG   = 1;
  localparam int COND_CARRY = 2;

  typedef enum logic [1:0] {
    FETCH,
    CAPTURE,
    EXEC,
    HALTED
  } fetch_state_t;

  function automatic logic branch_taken(input logic [2:0] cond, input logic zero,
                                        input logic neg, input logic carry);
    logic [2:0] flags;
    flags             = '0;
    flags[COND_ZERO]  = zero;
    flags[COND_NEG]   = neg;
    flags[COND_CARRY] = carry;
    return |(cond & flags);
  endfunction

endpackage

// File: rtl/crash_course_cpu_return_stack.sv
// Circular return-address stack; push on full overwrites the oldest entry.
// Single-cycle push/pop, top-of-stack readable combinationally.
module crash_course_cpu_return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, top_idx;
  logic [CW-1:0]    cnt_q, cnt_d;

  // ptr_q points at the next free slot, so the top lives one below it.
  assign top_idx     = ptr_q - PW'(1);
  assign data_o      = mem_q[top_idx];
  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == CW'(DEPTH));
  assign overflow_o  = push_i & full_o;
  assign underflow_o = pop_i & ~push_i & empty_o;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[ptr_q] <= data_i;
  end

endmodule

// File: rtl/crash_course_cpu_fetch_unit.sv
// Program sequencer: FETCH/CAPTURE/EXEC slot per instruction, next-PC resolution
// at the end of EXEC; exec_stall_i holds EXEC, HALTED exits only on reset.
module crash_course_cpu_fetch_unit
  import crash_course_cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  input  logic [INSTR_WIDTH-1:0] instr_rdata_i,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic                   instruction_valid_o,
  input  logic                   halt_enable_i,
  input  logic                   jump_enable_i,
  input  logic                   call_enable_i,
  input  logic                   return_enable_i,
  input  logic                   branch_enable_i,
  input  logic [2:0]             branch_condition_i,
  input  logic [7:0]             immediate_i,
  input  logic                   flag_zero_i,
  input  logic                   flag_negative_i,
  input  logic                   flag_carry_i,
  input  logic                   exec_stall_i,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   halted_o,
  output logic                   stack_error_o
);

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d, pc_inc, imm_addr;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   err_q, err_d;

  logic                   push, pop;
  logic [ADDR_WIDTH-1:0]  stk_top;
  logic                   stk_empty, stk_ovf, stk_unf, stk_full_unused;

  assign pc_inc   = pc_q + ADDR_WIDTH'(1);
  assign imm_addr = ADDR_WIDTH'(immediate_i);

  crash_course_cpu_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_stack (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .pop_i       (pop),
    .data_i      (pc_inc),
    .data_o      (stk_top),
    .empty_o     (stk_empty),
    .full_o      (stk_full_unused),
    .overflow_o  (stk_ovf),
    .underflow_o (stk_unf)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        instr_d = instr_rdata_i;
        state_d = EXEC;
      end
      EXEC: begin
        if (!exec_stall_i) begin
          state_d = FETCH;
          if (halt_enable_i) begin
            state_d = HALTED;
          end else if (jump_enable_i && return_enable_i) begin
            // An empty-stack return falls through to the next instruction.
            pop  = 1'b1;
            pc_d = stk_empty ? pc_inc : stk_top;
          end else if (jump_enable_i && call_enable_i) begin
            push = 1'b1;
            pc_d = imm_addr;
          end else if (jump_enable_i) begin
            pc_d = imm_addr;
          end else if (branch_enable_i &&
                       branch_taken(branch_condition_i, flag_zero_i,
                                    flag_negative_i, flag_carry_i)) begin
            pc_d = imm_addr;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
    err_d = err_q | stk_ovf | stk_unf;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      pc_q    <= '0;
      instr_q <= NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign instr_addr_o        = pc_q;
  assign pc_o                = pc_q;
  assign instruction_o       = instr_q;
  assign instruction_valid_o = (state_q == EXEC);
  assign halted_o            = (state_q == HALTED);
  assign stack_error_o       = err_q;

endmodule
